// File: rtl/axi_read_rr_arbiter.sv
// axi_read_rr_arbiter
//   Round-robin scheduler that shares one AXI read channel between MASTERS read
//   clients. One AR request is in flight at a time, tagged with ARID = master
//   index. Each master may have one outstanding burst. R beats are steered back
//   to their owner by RID.
//
// State table:
//   state | meaning
//   IDLE  | pick the next eligible master; the grant and AR capture happen here
//   ADDR  | AR valid on the AXI side, held stable until s_arready
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   m_arvalid/araddr/arlen     per-master read requests (packed, master i at slice i)
//   m_arready                  one-cycle one-hot grant pulse
//   m_rvalid/m_rlast/m_rdata   routed R beat (data broadcast to all masters)
//   m_rready                   per-master beat acceptance
//   m_busy                     per-master outstanding burst flag
//   s_ar*                      AXI AR channel towards the slave
//   s_r*                       AXI R channel from the slave
//   err                        sticky flag for a beat with unknown or idle RID
module axi_read_rr_arbiter #(
    parameter int MASTERS = 2,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MASTERS-1:0]          m_arvalid,
    input  logic [MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [MASTERS*4-1:0]        m_arlen,
    output logic [MASTERS-1:0]          m_arready,
    output logic [MASTERS-1:0]          m_rvalid,
    output logic [MASTERS-1:0]          m_rlast,
    output logic [DATA_W-1:0]           m_rdata,
    input  logic [MASTERS-1:0]          m_rready,
    output logic [MASTERS-1:0]          m_busy,
    output logic                        s_arvalid,
    output logic [ID_W-1:0]             s_arid,
    output logic [3:0]                  s_arlen,
    output logic [ADDR_W-1:0]           s_araddr,
    input  logic                        s_arready,
    input  logic                        s_rvalid,
    input  logic                        s_rlast,
    input  logic [ID_W-1:0]             s_rid,
    input  logic [DATA_W-1:0]           s_rdata,
    output logic                        s_rready,
    output logic                        err
);

    localparam int PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                s_arvalid_q, s_arvalid_d;
    logic [ID_W-1:0]     s_arid_q, s_arid_d;
    logic [3:0]          s_arlen_q, s_arlen_d;
    logic [ADDR_W-1:0]   s_araddr_q, s_araddr_d;
    logic [MASTERS-1:0]  m_busy_q, m_busy_d;
    logic                err_q, err_d;

    logic [MASTERS-1:0]  eligible;
    logic [MASTERS-1:0]  grant_oh;
    logic [MASTERS-1:0]  rid_hit;
    logic [MASTERS-1:0]  busy_clr;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_found;
    logic                rid_ok;
    int                  cand;

    assign eligible = m_arvalid & ~m_busy_q;

    // Rotating priority search starting just after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= MASTERS; k++) begin
            cand = (int'(rr_ptr_q) + k) % MASTERS;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(cand);
            end
        end
    end

    // R steering: a beat belongs to a master only if its RID matches an
    // outstanding burst; anything else is swallowed and flagged.
    always_comb begin
        rid_hit = '0;
        for (int i = 0; i < MASTERS; i++) begin
            rid_hit[i] = (s_rid == ID_W'(i)) && m_busy_q[i];
        end
    end

    assign rid_ok   = |rid_hit;
    assign s_rready = rid_ok ? |(rid_hit & m_rready) : 1'b1;
    assign m_rvalid = rid_hit & {MASTERS{s_rvalid}};
    assign m_rlast  = rid_hit & {MASTERS{s_rlast}};
    assign m_rdata  = s_rdata;
    assign busy_clr = rid_hit & {MASTERS{s_rvalid & s_rlast & s_rready}};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        s_arvalid_d = s_arvalid_q;
        s_arid_d    = s_arid_q;
        s_arlen_d   = s_arlen_q;
        s_araddr_d  = s_araddr_q;
        grant_oh    = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    grant_oh[grant_idx] = 1'b1;
                    rr_ptr_d    = grant_idx;
                    s_arvalid_d = 1'b1;
                    s_arid_d    = ID_W'(grant_idx);
                    s_araddr_d  = m_araddr[int'(grant_idx)*ADDR_W +: ADDR_W];
                    s_arlen_d   = m_arlen[int'(grant_idx)*4 +: 4];
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (s_arready) begin
                    s_arvalid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear and a grant for different masters in one cycle both land;
        // the same master cannot be granted here because eligibility uses m_busy_q.
        m_busy_d = (m_busy_q & ~busy_clr) | grant_oh;
        err_d    = err_q | (s_rvalid & ~rid_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= PTR_W'(MASTERS - 1);
            s_arvalid_q <= 1'b0;
            s_arid_q    <= '0;
            s_arlen_q   <= '0;
            s_araddr_q  <= '0;
            m_busy_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            s_arvalid_q <= s_arvalid_d;
            s_arid_q    <= s_arid_d;
            s_arlen_q   <= s_arlen_d;
            s_araddr_q  <= s_araddr_d;
            m_busy_q    <= m_busy_d;
            err_q       <= err_d;
        end
    end

    assign m_arready = grant_oh;
    assign s_arvalid = s_arvalid_q;
    assign s_arid    = s_arid_q;
    assign s_arlen   = s_arlen_q;
    assign s_araddr  = s_araddr_q;
    assign m_busy    = m_busy_q;
    assign err       = err_q;

endmodule
